// File: rtl/mmu_ctrl_gen.sv
// rtl/mmu_ctrl_gen.sv - systolic matmul controller: operand load, skewed feed, shadow capture, byte readout
// Readout of one result overlaps load and compute of the next; CAPTURE waits for the readout engine.

module mmu_ctrl_gen #(
  parameter int N     = 2,
  parameter int ACC_W = 16,
  parameter int IDXW  = (N > 1) ? $clog2(N) : 1,
  parameter int AW    = $clog2(2 * N * N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic                   clear,
  output logic [N-1:0]           a_en,
  output logic [N-1:0]           b_en,
  output logic [N*IDXW-1:0]      a_idx,
  output logic [N*IDXW-1:0]      b_idx,
  input  logic [N*N*ACC_W-1:0]   c_flat,
  input  logic                   out_mode,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);

  localparam int NN  = N * N;
  localparam int BPE = ACC_W / 8;
  localparam int TOT = NN * BPE;
  localparam int KW  = $clog2(3 * N);
  localparam int EW  = $clog2(NN + 1);
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam int RW  = $clog2(TOT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_WAIT, S_CAPTURE} state_e;
  typedef enum logic {RD_IDLE, RD_BUSY} rd_e;

  state_e              state_q, state_d;
  rd_e                 rd_q, rd_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [KW-1:0]       k_q, k_d;
  logic [NN*ACC_W-1:0] shadow_q, shadow_d;
  logic                mode_q, mode_d;
  logic [EW-1:0]       elem_q, elem_d;
  logic [BW-1:0]       bsel_q, bsel_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  int                  k_int;

  // Mode 1 saturates the signed element to one byte; mode 0 returns byte b counted from the MSB.
  function automatic logic [7:0] pick(input logic [NN*ACC_W-1:0] src, input logic mode,
                                      input logic [EW-1:0] e, input logic [BW-1:0] b);
    logic signed [ACC_W-1:0] v;
    v = src[e*ACC_W +: ACC_W];
    if (mode) begin
      if (v > 127)       pick = 8'h7f;
      else if (v < -128) pick = 8'h80;
      else               pick = v[7:0];
    end else begin
      pick = v[(BPE-1-b)*8 +: 8];
    end
  endfunction

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign mem_we    = in_valid && in_ready;
  assign mem_addr  = addr_q;
  assign clear     = (state_q != S_COMPUTE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign k_int     = int'(k_q);

  always_comb begin
    a_en  = '0;
    a_idx = '0;
    if (state_q == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        if (k_int >= i && k_int - i < N) begin
          a_en[i]                = 1'b1;
          a_idx[i*IDXW +: IDXW]  = IDXW'(k_int - i);
        end
      end
    end
  end

  assign b_en  = a_en;
  assign b_idx = a_idx;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_valid) begin
          if (addr_q == AW'(2 * NN - 1)) begin
            addr_d  = '0;
            state_d = S_COMPUTE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_COMPUTE: begin
        if (k_q == KW'(3 * N - 2)) begin
          k_d     = '0;
          state_d = (rd_q == RD_IDLE) ? S_CAPTURE : S_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      // Leave WAIT on the cycle the readout finishes so CAPTURE follows done directly.
      S_WAIT:    if (rd_d == RD_IDLE) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    logic          adv;
    logic [EW-1:0] adv_e;
    logic [BW-1:0] adv_b;
    logic          adv_m;
    rd_d        = rd_q;
    shadow_d    = shadow_q;
    mode_d      = mode_q;
    elem_d      = elem_q;
    bsel_d      = bsel_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done        = 1'b0;
    adv         = 1'b0;
    adv_e       = elem_q;
    adv_b       = bsel_q;
    adv_m       = mode_q;
    if (state_q == S_CAPTURE) begin
      // First byte comes straight from c_flat since the shadow loads on this same edge.
      shadow_d    = c_flat;
      mode_d      = out_mode;
      rd_d        = RD_BUSY;
      rem_d       = out_mode ? RW'(NN - 1) : RW'(TOT - 1);
      out_valid_d = 1'b1;
      out_data_d  = pick(c_flat, out_mode, '0, '0);
      adv         = 1'b1;
      adv_e       = '0;
      adv_b       = '0;
      adv_m       = out_mode;
    end else if (rd_q == RD_BUSY && out_valid_q && out_ready) begin
      if (rem_q == '0) begin
        done        = 1'b1;
        rd_d        = RD_IDLE;
        out_valid_d = 1'b0;
      end else begin
        rem_d      = rem_q - 1'b1;
        out_data_d = pick(shadow_q, mode_q, elem_q, bsel_q);
        adv        = 1'b1;
      end
    end
    if (adv) begin
      if (adv_m || adv_b == BW'(BPE - 1)) begin
        elem_d = adv_e + 1'b1;
        bsel_d = '0;
      end else begin
        elem_d = adv_e;
        bsel_d = adv_b + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= RD_IDLE;
      addr_q      <= '0;
      k_q         <= '0;
      shadow_q    <= '0;
      mode_q      <= 1'b0;
      elem_q      <= '0;
      bsel_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      bsel_q      <= bsel_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mmu_ctrl_gen.sv
// tb/tb_mmu_ctrl_gen.sv - scoreboard bench for mmu_ctrl_gen with a behavioural systolic array
// N=2 instance carries the data tests; an N=3 instance checks the feed schedule.

module tb_mmu_ctrl_gen;
  localparam int N = 2, ACC_W = 16, IDXW = 1, AW = 3;
  localparam int N3 = 3, IDXW3 = 2, AW3 = 5;

  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0, out_ready = 1, out_mode = 0, force_c = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, mem_we, clear, out_valid, done;
  logic [AW-1:0] mem_addr;
  logic [N-1:0] a_en, b_en;
  logic [N*IDXW-1:0] a_idx, b_idx;
  logic [N*N*ACC_W-1:0] c_flat, model_flat, forced;
  logic [7:0] out_data;

  logic in_valid3 = 0;
  logic in_ready3, mem_we3, clear3, out_valid3, done3;
  logic [AW3-1:0] mem_addr3;
  logic [N3-1:0] a_en3, b_en3;
  logic [N3*IDXW3-1:0] a_idx3, b_idx3;
  logic [N3*N3*ACC_W-1:0] c3 = '0;
  logic [7:0] out_data3;

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];
  bit last_q[$];
  logic [7:0] ed, held;
  bit el, stalled;

  always #5 clk = ~clk;

  mmu_ctrl_gen #(.N(N), .ACC_W(ACC_W)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .clear(clear), .a_en(a_en), .b_en(b_en), .a_idx(a_idx), .b_idx(b_idx),
    .c_flat(c_flat), .out_mode(out_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done));

  mmu_ctrl_gen #(.N(N3), .ACC_W(ACC_W)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .clear(clear3), .a_en(a_en3), .b_en(b_en3), .a_idx(a_idx3), .b_idx(b_idx3),
    .c_flat(c3), .out_mode(1'b0), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(1'b1), .done(done3));

  // Behavioural array: operands shift right/down one cell per cycle; accumulators restart on the first COMPUTE cycle.
  logic [7:0] tbmem [0:2*N*N-1];
  logic signed [ACC_W-1:0] acc [0:N-1][0:N-1];
  int ar [0:N-1][0:N-1];
  int br [0:N-1][0:N-1];
  bit fresh;

  always @(posedge clk) if (mem_we) tbmem[mem_addr] <= in_byte;

  always @(posedge clk) begin
    int ain, bin;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        acc[i][j] <= '0; ar[i][j] <= 0; br[i][j] <= 0;
      end
      fresh <= 1;
    end else if (clear) begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        ar[i][j] <= 0; br[i][j] <= 0;
      end
      fresh <= 1;
    end else begin
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
        if (j == 0) ain = a_en[i] ? int'($signed(tbmem[i*N + int'(a_idx[i*IDXW +: IDXW])])) : 0;
        else        ain = ar[i][(j > 0) ? j-1 : 0];
        if (i == 0) bin = b_en[j] ? int'($signed(tbmem[N*N + int'(b_idx[j*IDXW +: IDXW])*N + j])) : 0;
        else        bin = br[(i > 0) ? i-1 : 0][j];
        acc[i][j] <= (fresh ? 16'sd0 : acc[i][j]) + 16'(ain * bin);
        ar[i][j] <= ain;
        br[i][j] <= bin;
      end
      fresh <= 0;
    end
  end

  always_comb begin
    model_flat = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
      model_flat[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
  end
  assign c_flat = force_c ? forced : model_flat;

  always @(negedge clk) begin
    if (stalled) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%0b data=%02h want valid=1 data=%02h", out_valid, out_data, held);
      end
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra_byte: got %02h want no byte", out_data);
      end else begin
        ed = exp_q.pop_front();
        el = last_q.pop_front();
        n_cmp++;
        if (out_data !== ed) begin n_err++; $display("FAIL out_byte: got %02h want %02h", out_data, ed); end
        n_cmp++;
        if (done !== el) begin n_err++; $display("FAIL done_flag: got %0b want %0b", done, el); end
      end
    end else if (done) begin
      n_cmp++; n_err++;
      $display("FAIL done_no_handshake: got done=1 want 0");
    end
    stalled <= rst_n && out_valid && !out_ready;
    held <= out_data;
  end

  task automatic push_expected(input logic [7:0] a[4], input logic [7:0] b[4], input bit mode);
    int c;
    logic [15:0] cv;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      c = 0;
      for (int m = 0; m < N; m++) c += int'($signed(a[i*N+m])) * int'($signed(b[m*N+j]));
      cv = 16'(c);
      if (!mode) begin
        exp_q.push_back(cv[15:8]); last_q.push_back(0);
        exp_q.push_back(cv[7:0]);  last_q.push_back(i == N-1 && j == N-1);
      end else begin
        exp_q.push_back(c > 127 ? 8'h7f : (c < -128 ? 8'h80 : cv[7:0]));
        last_q.push_back(i == N-1 && j == N-1);
      end
    end
  endtask

  task automatic drive_pair(input logic [7:0] a[4], input logic [7:0] b[4], input int count, input bit gap);
    for (int idx = 0; idx < count; idx++) begin
      int w;
      if (gap && idx == 3) begin
        in_valid = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_addr !== 3'd3 || mem_we !== 1'b0) begin
          n_err++; $display("FAIL gap_hold: got addr=%0d we=%0b want addr=3 we=0", mem_addr, mem_we);
        end
      end
      if (idx < 4) in_byte = a[idx]; else in_byte = b[idx-4];
      in_valid = 1;
      w = 0;
      while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
      if (w >= 200) begin n_cmp++; n_err++; $display("FAIL in_ready_timeout: got in_ready=0 want 1"); end
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) begin n_cmp++; n_err++; $display("FAIL out_valid_timeout: got 0 want 1"); end
  endtask

  task automatic wait_drain(input bit toggle);
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 400) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (w >= 400) begin n_err++; $display("FAIL drain_timeout: got %0d bytes left want 0", exp_q.size()); end
    out_ready = 1;
  endtask

  task automatic rand_pair(output logic [7:0] a[4], output logic [7:0] b[4]);
    for (int i = 0; i < 4; i++) begin a[i] = 8'($urandom_range(0, 15)); b[i] = 8'($urandom_range(0, 15)); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 5;
    if (in_ready !== 1'b1 || clear !== 1'b1) begin n_err++; $display("FAIL rst_ready_clear: got %0b%0b want 11", in_ready, clear); end
    if (mem_addr !== '0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    if (out_valid !== 1'b0 || out_data !== 8'h00 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_out: got v=%0b d=%02h done=%0b want 0 00 0", out_valid, out_data, done);
    end
    if (a_en !== '0 || b_en !== '0 || a_idx !== '0 || b_idx !== '0) begin n_err++; $display("FAIL rst_feed: got %0b %0b want 0", a_en, b_en); end
    if (a_en3 !== '0 || in_ready3 !== 1'b1) begin n_err++; $display("FAIL rst_n3: got en=%0b rdy=%0b want 0 1", a_en3, in_ready3); end
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [7:0] a[4], b[4];
    int lat;
    a = '{8'd1, 8'd2, 8'd3, 8'd4};
    b = '{8'd5, 8'd6, 8'd7, 8'd8};
    out_mode = 0; out_ready = 1;
    push_expected(a, b, 0);
    drive_pair(a, b, 8, 0);
    n_cmp++;
    if (a_en !== 2'b01 || b_en !== 2'b01 || clear !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL first_feed: got a_en=%b clr=%0b rdy=%0b want 01 0 0", a_en, clear, in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (lat !== 7) begin n_err++; $display("FAIL latency: got %0d want 7", lat); end
    wait_drain(0);
  endtask

  task automatic test_feed_n3();
    logic [N3-1:0] een;
    logic [N3*IDXW3-1:0] eidx;
    in_valid3 = 1;
    repeat (2 * N3 * N3) @(posedge clk);
    #1;
    in_valid3 = 0;
    for (int k = 0; k < 3 * N3 - 1; k++) begin
      een = '0; eidx = '0;
      for (int i = 0; i < N3; i++)
        if (k >= i && k - i < N3) begin een[i] = 1; eidx[i*IDXW3 +: IDXW3] = 2'(k - i); end
      n_cmp += 2;
      if (a_en3 !== een || a_idx3 !== eidx) begin
        n_err++; $display("FAIL feed_a k=%0d: got en=%b idx=%h want en=%b idx=%h", k, a_en3, a_idx3, een, eidx);
      end
      if (b_en3 !== een || b_idx3 !== eidx || clear3 !== 1'b0) begin
        n_err++; $display("FAIL feed_b k=%0d: got en=%b idx=%h clr=%0b want en=%b idx=%h clr=0", k, b_en3, b_idx3, clear3, een, eidx);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (clear3 !== 1'b1 || a_en3 !== '0) begin n_err++; $display("FAIL feed_end: got clr=%0b en=%b want 1 000", clear3, a_en3); end
  endtask

  task automatic test_mode1_sat();
    logic [7:0] a[4], b[4];
    rand_pair(a, b);
    forced = {16'hFFFB, 16'h007F, 16'hFF38, 16'h012C};
    force_c = 1; out_mode = 1;
    exp_q.push_back(8'h7F); last_q.push_back(0);
    exp_q.push_back(8'h80); last_q.push_back(0);
    exp_q.push_back(8'h7F); last_q.push_back(0);
    exp_q.push_back(8'hFB); last_q.push_back(1);
    drive_pair(a, b, 8, 0);
    wait_drain(0);
    force_c = 0; out_mode = 0;
  endtask

  task automatic test_backpressure();
    logic [7:0] a[4], b[4];
    rand_pair(a, b);
    out_ready = 0;
    push_expected(a, b, 0);
    drive_pair(a, b, 8, 1);
    wait_drain(1);
    rand_pair(a, b);
    out_mode = 1;
    push_expected(a, b, 1);
    drive_pair(a, b, 8, 0);
    wait_drain(1);
    out_mode = 0;
  endtask

  task automatic test_overlap();
    logic [7:0] a[4], b[4], c[4], d[4];
    int w;
    rand_pair(a, b);
    rand_pair(c, d);
    out_ready = 0;
    push_expected(a, b, 0);
    drive_pair(a, b, 8, 0);
    wait_valid();
    push_expected(c, d, 0);
    drive_pair(c, d, 8, 0);
    repeat (3 * N - 1) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || clear !== 1'b1 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL wait_state: got rdy=%0b clr=%0b v=%0b want 0 1 1", in_ready, clear, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    w = 0;
    while (!done && w < 50) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (w >= 50) begin n_err++; $display("FAIL first_done_timeout: got 0 want 1"); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL capture_cycle: got rdy=%0b v=%0b want 0 0", in_ready, out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL after_capture: got rdy=%0b v=%0b want 1 1", in_ready, out_valid); end
    wait_drain(0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] a[4], b[4];
    rand_pair(a, b);
    out_ready = 0;
    drive_pair(a, b, 8, 0);
    wait_valid();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL rst_readout: got v=%0b done=%0b rdy=%0b want 0 0 1", out_valid, done, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    drive_pair(a, b, 3, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    n_cmp++;
    if (mem_addr !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_load: got addr=%0d rdy=%0b v=%0b want 0 1 0", mem_addr, in_ready, out_valid);
    end
    rand_pair(a, b);
    push_expected(a, b, 0);
    drive_pair(a, b, 8, 0);
    wait_drain(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_feed_n3();
    test_mode1_sat();
    test_backpressure();
    test_overlap();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover: got %0d bytes want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmu_ctrl_gen.md
# mmu_ctrl_gen

Parametrised control unit for an N×N systolic matrix-multiply array. It accepts the two N×N operand matrices as a valid/ready byte stream and drives the operand-memory address. It sequences the skewed row/column feed into the array, captures the finished accumulators into a shadow buffer, and streams results out as bytes with valid/ready back-pressure. Readout of one result overlaps loading and computing of the next.

## Interface
- N, default 2: array dimension; N ≥ 2.
- ACC_W, default 16: accumulator width; multiple of 8.
- IDXW, derived: clog2(N), minimum 1.
- AW, derived: clog2(2·N·N).
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  operand byte present.
- in_ready  out  1  block can accept an operand byte.
- mem_we  out  1  in_valid && in_ready; operand memory writes at mem_addr.
- mem_addr  out  AW  operand byte index.
- clear  out  1  array accumulator clear.
- a_en / b_en  out  N each  per-row (A) and per-column (B) feed enable.
- a_idx / b_idx  out  N·IDXW each  per-row / per-column operand index, flattened with lane 0 in the LSBs.
- c_flat  in  N·N·ACC_W  signed array accumulators, row-major, element 0 in the LSBs.
- out_mode  in  1  0 = full-width bytes, 1 = saturated single byte per element.
- out_data  out  8  result byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- done  out  1  one-cycle pulse on the final result-byte handshake.

## Operation
- Main FSM states: IDLE, LOAD, COMPUTE, WAIT, CAPTURE. A separate readout engine runs alongside it with states RD_IDLE and RD_BUSY.
- IDLE: in_ready=1. The first accepted byte is written at address 0 and moves the FSM to LOAD.
- LOAD: in_ready=1. mem_addr counts accepted bytes.
  - Addresses 0..N²−1 hold A, row-major. Addresses N²..2N²−1 hold B, row-major.
  - When the byte at 2N²−1 is accepted, mem_addr wraps to 0 and the FSM goes to COMPUTE.
  - When in_valid=0, the FSM holds its state and mem_addr.
- COMPUTE: in_ready=0. Cycle counter k runs 0..3N−2.
  - Row i: a_en[i] = (k ≥ i && k−i < N), and a_idx[i] = k−i when enabled, 0 otherwise.
  - Column j uses the same rule for b_en and b_idx.
  - All enables are 0 for k > 2N−2; these cycles let the array drain.
  - After k = 3N−2: go to CAPTURE if the readout engine is in RD_IDLE, otherwise go to WAIT.
- WAIT: in_ready=0. Hold until the readout engine returns to RD_IDLE, then go to CAPTURE on the next cycle.
- CAPTURE: one cycle.
  - Copy c_flat into the shadow buffer and latch out_mode.
  - Start the readout engine (RD_BUSY).
  - Go to IDLE.
- clear = 1 whenever the FSM is not in COMPUTE. The array therefore starts every COMPUTE from zero.
- Readout in mode 0: ACC_W/8 bytes per element, MSB first, elements in row-major order, N²·ACC_W/8 bytes in total.
- Readout in mode 1: one byte per element, signed saturation of the element to the range −128..127, N² bytes in total.
- The readout engine returns to RD_IDLE on the final handshake, in the same cycle that done pulses.

## Timing
- Reset values:
  - FSM = IDLE, readout engine = RD_IDLE, mem_addr = 0, k = 0.
  - a_en, b_en, a_idx, b_idx = 0.
  - out_valid = 0, out_data = 0, done = 0, shadow buffer = 0.
  - clear = 1 and in_ready = 1, both derived from the IDLE state.
- Reset asserted mid-LOAD or mid-readout: everything is abandoned. The next load starts at address 0, and no done pulse is issued.
- Feed outputs are combinational from the registered state and k. The first feed appears in the first COMPUTE cycle, one cycle after the last byte is accepted.
- Latency from the last load byte to out_valid = 3N+1 cycles when no WAIT occurs: 3N−1 COMPUTE cycles, 1 CAPTURE cycle, then out_valid registered on the next edge.
- out_valid and out_data are registered.
  - Once out_valid rises, out_data is held stable until out_ready=1.
  - At most one byte is transferred per cycle, and there are no bubbles while out_ready stays 1.
- LOAD of the next matrix pair may proceed while the readout engine is in RD_BUSY. Only CAPTURE is blocked, via WAIT.
- Shadow buffer contents are never modified while the readout engine is in RD_BUSY.

## Test plan
- N=2, mode 0, out_ready=1, loading A=[[1,2],[3,4]] and B=[[5,6],[7,8]] with a behavioural array model. Required response:
  - out_data bytes are 00 13 00 16 00 2B 00 32.
  - done pulses with the 8th byte.
  - Latency from the last load byte to out_valid is 7 cycles.
- N=3, feed schedule. Required response: at k=2, a_en=111 and a_idx={0,1,2} for rows {2,1,0}. At k=4, a_en=100 and a_idx[2]=2. At k=5..7, all enables are 0.
- Mode 1, with forced c_flat = {300, −200, 127, −5}. Required response: bytes 7F 80 7F FB.
- Back-pressure, with out_ready toggling every other cycle. Required response: each byte is held stable while stalled, and no byte is lost or duplicated.
- Overlap, starting a second load while the first readout is stalled (out_ready=0). Required response:
  - The second matrix pair loads fully, and the FSM enters WAIT after COMPUTE.
  - The second CAPTURE occurs one cycle after the first readout's done pulse.
  - The second result stream is correct.
- Reset mid-LOAD after 3 bytes. Required response: mem_addr=0, in_ready=1, out_valid=0. A subsequent full load produces correct results.
